// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: FSM encoding, slice width
// and helpers that size the nibble index from the operand width.
package nibble_adder_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic int nib_count(input int width);
      return width / NIBBLE_W;
   endfunction

   // A single-nibble build still needs a 1-bit index register.
   function automatic int idx_width(input int width);
      int nib;
      nib = width / NIBBLE_W;
      return (nib > 1) ? $clog2(nib) : 1;
   endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand and result handshake bundle for nibble_serial_adder.
// The adder is the slave; the producer/consumer side is the master.
interface nibble_serial_adder_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
endinterface

// File: rtl/nibble_serial_adder_cla.sv
// Existing 4-bit carry-lookahead adder slice, fully combinational.
module CarryLookAhead_Adder (
   output logic [3:0] Sum,
   output logic       Cout,
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic       Cin
);
   logic [3:0] g_s;
   logic [3:0] p_s;
   logic [4:0] c_s;

   assign g_s = A & B;
   assign p_s = A ^ B;

   assign c_s[0] = Cin;
   assign c_s[1] = g_s[0] | (p_s[0] & Cin);
   assign c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & Cin);
   assign c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                 | (p_s[2] & p_s[1] & p_s[0] & Cin);
   assign c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                 | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
                 | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & Cin);

   assign Sum  = p_s ^ c_s[3:0];
   assign Cout = c_s[4];
endmodule

// File: rtl/nibble_serial_adder.sv
// Wide adder that reuses one 4-bit CLA slice, one nibble per clock, LSB first,
// with the inter-nibble carry held in a register.
module nibble_serial_adder
   import nibble_adder_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   nibble_serial_adder_if.slave  bus
);
   localparam int NIB = nib_count(WIDTH);
   localparam int IW  = idx_width(WIDTH);
   localparam logic [IW-1:0] IDX_LAST = IW'(NIB - 1);

   localparam logic [1:0] S_IDLE = IDLE;
   localparam logic [1:0] S_RUN  = RUN;
   localparam logic [1:0] S_DONE = DONE;

   logic [1:0]       state_q,     state_d;
   logic [IW-1:0]    idx_q,       idx_d;
   logic [WIDTH-1:0] a_q,         a_d;
   logic [WIDTH-1:0] b_q,         b_d;
   logic             carry_q,     carry_d;
   logic [WIDTH-1:0] sum_q,       sum_d;
   logic             cout_q,      cout_d;
   logic             ovf_q,       ovf_d;
   logic             out_valid_q, out_valid_d;

   logic [3:0] nib_a_s;
   logic [3:0] nib_b_s;
   logic [3:0] cla_sum_s;
   logic       cla_cout_s;

   always_comb begin
      nib_a_s = 4'd0;
      nib_b_s = 4'd0;
      for (int i = 0; i < NIB; i++) begin
         if (idx_q == IW'(i)) begin
            nib_a_s = a_q[i*NIBBLE_W +: NIBBLE_W];
            nib_b_s = b_q[i*NIBBLE_W +: NIBBLE_W];
         end else begin
            nib_a_s = nib_a_s;
            nib_b_s = nib_b_s;
         end
      end
   end

   CarryLookAhead_Adder u_cla (
      .Sum  (cla_sum_s),
      .Cout (cla_cout_s),
      .A    (nib_a_s),
      .B    (nib_b_s),
      .Cin  (carry_q)
   );

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      a_d         = a_q;
      b_d         = b_q;
      carry_d     = carry_q;
      sum_d       = sum_q;
      cout_d      = cout_q;
      ovf_d       = ovf_q;
      out_valid_d = out_valid_q;
      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               a_d     = bus.a;
               b_d     = bus.b;
               carry_d = bus.cin;
               idx_d   = '0;
               state_d = S_RUN;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            for (int i = 0; i < NIB; i++) begin
               if (idx_q == IW'(i)) begin
                  sum_d[i*NIBBLE_W +: NIBBLE_W] = cla_sum_s;
               end else begin
                  sum_d = sum_d;
               end
            end
            carry_d = cla_cout_s;
            idx_d   = idx_q + IW'(1);
            // Overflow uses the freshly written top nibble, not the stale sum_q.
            if (idx_q == IDX_LAST) begin
               idx_d       = '0;
               cout_d      = cla_cout_s;
               ovf_d       = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_d[WIDTH-1] != a_q[WIDTH-1]);
               out_valid_d = 1'b1;
               state_d     = S_DONE;
            end else begin
               state_d = S_RUN;
            end
         end
         S_DONE: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end else begin
               state_d = S_DONE;
            end
         end
         default: begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         carry_q     <= 1'b0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         a_q         <= a_d;
         b_q         <= b_d;
         carry_q     <= carry_d;
         sum_q       <= sum_d;
         cout_q      <= cout_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.in_ready  = (state_q == S_IDLE) && !rst;
   assign bus.out_valid = out_valid_q;
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;
   assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder at WIDTH=16, plus directed checks
// on a WIDTH=4 instance.
module tb_nibble_serial_adder;

   typedef struct packed {
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
   } res_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   nibble_serial_adder_if #(.WIDTH(16)) bus16 ();
   nibble_serial_adder_if #(.WIDTH(4))  bus4 ();

   nibble_serial_adder #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));
   nibble_serial_adder #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4.slave));

   res_t sbq[$];
   int   total = 0;
   int   bad   = 0;
   int   rcv   = 0;
   bit   drv_done = 1'b0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic res_t model16(input logic [15:0] a, input logic [15:0] b, input logic c);
      logic [16:0] s;
      res_t r;
      s      = {1'b0, a} + {1'b0, b} + {16'd0, c};
      r.sum  = s[15:0];
      r.cout = s[16];
      r.ovf  = (a[15] == b[15]) && (s[15] != a[15]);
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Push on accepted operands, pop and compare on consumed results.
   always @(negedge clk) begin : monitor
      res_t e;
      if (rst) begin
         sbq.delete();
      end else begin
         if (bus16.out_valid && bus16.out_ready) begin
            if (sbq.size() == 0) begin
               check_val("sb_unexpected_result", 32'd1, 32'd0);
            end else begin
               e = sbq.pop_front();
               check_val("sb_sum",  {16'd0, bus16.sum}, {16'd0, e.sum});
               check_val("sb_cout", {31'd0, bus16.cout}, {31'd0, e.cout});
               check_val("sb_ovf",  {31'd0, bus16.ovf},  {31'd0, e.ovf});
               rcv++;
            end
         end
         if (bus16.in_valid && bus16.in_ready) begin
            sbq.push_back(model16(bus16.a, bus16.b, bus16.cin));
         end
      end
   end

   task automatic wait_ready16();
      int g = 0;
      while (!bus16.in_ready && g < 100) begin
         tick();
         g++;
      end
      if (!bus16.in_ready) check_val("in_ready_timeout", 32'd0, 32'd1);
   endtask

   task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic c,
                       input int hold, input string tag);
      res_t e;
      int   lat;
      e = model16(a, b, c);
      wait_ready16();
      bus16.a = a; bus16.b = b; bus16.cin = c; bus16.in_valid = 1'b1;
      tick();
      bus16.in_valid = 1'b0;
      lat = 1;
      while (!bus16.out_valid && lat < 50) begin
         tick();
         lat++;
      end
      check_val({tag, "_lat"}, lat, 32'd5);
      for (int h = 0; h < hold; h++) begin
         check_val({tag, "_hold_sum"},   {16'd0, bus16.sum}, {16'd0, e.sum});
         check_val({tag, "_hold_cout"},  {31'd0, bus16.cout}, {31'd0, e.cout});
         check_val({tag, "_hold_rdy"},   {31'd0, bus16.in_ready}, 32'd0);
         check_val({tag, "_hold_valid"}, {31'd0, bus16.out_valid}, 32'd1);
         bus16.a = ~a; bus16.b = a ^ b; bus16.cin = ~c;
         bus16.in_valid = h[0];
         tick();
      end
      bus16.in_valid  = 1'b0;
      bus16.out_ready = 1'b1;
      tick();
      bus16.out_ready = 1'b0;
      check_val({tag, "_rdy_after"},   {31'd0, bus16.in_ready}, 32'd1);
      check_val({tag, "_valid_after"}, {31'd0, bus16.out_valid}, 32'd0);
   endtask

   task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic c, input string tag);
      logic [4:0] s;
      int lat;
      s = {1'b0, a} + {1'b0, b} + {4'd0, c};
      bus4.a = a; bus4.b = b; bus4.cin = c; bus4.in_valid = 1'b1;
      check_val({tag, "_rdy"}, {31'd0, bus4.in_ready}, 32'd1);
      tick();
      bus4.in_valid = 1'b0;
      lat = 1;
      while (!bus4.out_valid && lat < 20) begin
         tick();
         lat++;
      end
      check_val({tag, "_lat"},  lat, 32'd2);
      check_val({tag, "_sum"},  {28'd0, bus4.sum}, {28'd0, s[3:0]});
      check_val({tag, "_cout"}, {31'd0, bus4.cout}, {31'd0, s[4]});
      check_val({tag, "_ovf"},  {31'd0, bus4.ovf},
                {31'd0, (a[3] == b[3]) && (s[3] != a[3])});
      bus4.out_ready = 1'b1;
      tick();
      bus4.out_ready = 1'b0;
   endtask

   initial begin
      int rcv0;
      bus16.in_valid = 1'b0; bus16.out_ready = 1'b0; bus16.a = 16'd0; bus16.b = 16'd0; bus16.cin = 1'b0;
      bus4.in_valid  = 1'b0; bus4.out_ready  = 1'b0; bus4.a  = 4'd0;  bus4.b  = 4'd0;  bus4.cin  = 1'b0;
      rst = 1'b1;
      repeat (3) tick();
      check_val("rst_in_ready16", {31'd0, bus16.in_ready}, 32'd0);
      check_val("rst_in_ready4",  {31'd0, bus4.in_ready},  32'd0);
      rst = 1'b0;
      #1;
      check_val("rst_rdy_after",  {31'd0, bus16.in_ready}, 32'd1);
      check_val("rst_out_valid",  {31'd0, bus16.out_valid}, 32'd0);
      check_val("rst_sum",        {16'd0, bus16.sum}, 32'd0);
      check_val("rst_cout",       {31'd0, bus16.cout}, 32'd0);
      check_val("rst_ovf",        {31'd0, bus16.ovf}, 32'd0);

      op16(16'hFFFF, 16'h0001, 1'b0, 0, "wrap");
      op16(16'h7FFF, 16'h0001, 1'b0, 0, "posovf");
      op16(16'h8000, 16'h8000, 1'b0, 0, "negovf");
      op16(16'h1234, 16'h4321, 1'b1, 6, "bp");

      op4(4'hA, 4'hF, 1'b0, "w4_c0");
      op4(4'hA, 4'hF, 1'b1, "w4_c1");
      op4(4'h7, 4'h1, 1'b0, "w4_ovf");

      // Abort in the second RUN cycle.
      wait_ready16();
      bus16.a = 16'h00FF; bus16.b = 16'h0001; bus16.cin = 1'b0; bus16.in_valid = 1'b1;
      tick();
      bus16.in_valid = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      check_val("mid_rst_rdy", {31'd0, bus16.in_ready}, 32'd0);
      tick();
      rst = 1'b0;
      #1;
      check_val("mid_rst_sum",   {16'd0, bus16.sum}, 32'd0);
      check_val("mid_rst_cout",  {31'd0, bus16.cout}, 32'd0);
      check_val("mid_rst_ovf",   {31'd0, bus16.ovf}, 32'd0);
      check_val("mid_rst_valid", {31'd0, bus16.out_valid}, 32'd0);
      check_val("mid_rst_rdy2",  {31'd0, bus16.in_ready}, 32'd1);
      for (int i = 0; i < 8; i++) begin
         tick();
         check_val("mid_rst_no_valid", {31'd0, bus16.out_valid}, 32'd0);
      end
      op16(16'h0003, 16'h0004, 1'b0, 0, "post_rst");

      rcv0 = rcv;
      fork
         begin : driver
            bit acc;
            int g;
            for (int n = 0; n < 500; n++) begin
               repeat ($urandom_range(0, 2)) tick();
               bus16.a = 16'($urandom); bus16.b = 16'($urandom); bus16.cin = 1'($urandom);
               if (n % 25 == 0) begin
                  bus16.a = 16'hFFFF; bus16.b = 16'($urandom_range(0, 1));
               end
               bus16.in_valid = 1'b1;
               acc = 1'b0;
               g   = 0;
               while (!acc && g < 200) begin
                  acc = bus16.in_ready;
                  tick();
                  g++;
               end
               bus16.in_valid = 1'b0;
               if (!acc) check_val("rand_accept_timeout", 32'd0, 32'd1);
            end
            drv_done = 1'b1;
         end
         begin : consumer
            int g = 0;
            while (!(drv_done && sbq.size() == 0) && g < 40000) begin
               bus16.out_ready = 1'($urandom_range(0, 1));
               tick();
               g++;
            end
            bus16.out_ready = 1'b0;
            if (g >= 40000) check_val("rand_drain_timeout", 32'd0, 32'd1);
         end
      join
      check_val("rand_count", rcv - rcv0, 32'd500);
      check_val("rand_sb_empty", sbq.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle wide adder that feeds the team's 4-bit carry-lookahead adder one nibble per clock. It accepts WIDTH-bit operands over a valid/ready handshake and steps through them LSB nibble first, chaining each nibble's carry-out into the next nibble's carry-in through a register. It presents the registered WIDTH-bit sum, carry-out and signed overflow on an output valid/ready handshake. Use it where a wide add is needed but only one 4-bit CLA slice is budgeted.

## Interface
- WIDTH, 16: operand/sum width; must be a multiple of 4 and ≥ 4; NIB = WIDTH/4.
- clk  in  1  rising-edge clock.
- rst  in  1  reset; **one clock; reset is synchronous and active-high**.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A (unsigned or two's complement).
- b  in  WIDTH  operand B.
- cin  in  1  carry into bit 0.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  a + b + cin, mod 2^WIDTH.
- cout  out  1  carry out of bit WIDTH-1.
- ovf  out  1  signed overflow: a[MSB]==b[MSB] and sum[MSB]!=a[MSB].

## Operation
- State machine states:
  - IDLE: in_ready=1. When in_valid is high, latch a, b and cin, clear the nibble index and go to RUN.
  - RUN: each cycle present nibble idx of a and b, plus carry_reg, to the CLA slice. Write the slice sum into sum[4*idx+3:4*idx], load carry_reg from the slice cout, and increment idx. After idx = NIB-1, go to DONE.
  - DONE: out_valid=1 and outputs held stable. When out_ready is high, go to IDLE.
- in_ready is high only in IDLE and forced low while rst is high. Operand changes outside an accept are ignored.
- On the first RUN cycle carry_reg = latched cin.
- In DONE: cout = carry_reg, and ovf is computed from the latched a/b MSBs and the final sum MSB.
- No accept is taken in DONE, even with out_ready high; a new operand can be accepted the cycle after the DONE→IDLE transition.
- rst high at any clock edge, including mid-RUN or in DONE with out_valid high, aborts the operation:
  - state goes to IDLE;
  - sum, cout, ovf, out_valid, idx and carry_reg are cleared to 0;
  - the in-flight result is discarded and never presented.
- Reset values: in_ready 0 while rst is high and 1 the cycle after rst drops; out_valid 0; sum 0; cout 0; ovf 0.
- Arithmetic: modulo 2^WIDTH with no saturation. The unsigned carry goes to cout and the signed overflow to ovf; both are always reported.

## Timing
- Accept at edge k (IDLE, in_valid=1). RUN occupies cycles k+1 … k+NIB, with the nibble-i result written at edge k+1+i.
- out_valid rises after edge k+NIB, giving a latency of NIB+1 cycles from accept to out_valid (5 at WIDTH=16, 2 at WIDTH=4).
- Handshake at edge m (DONE, out_ready=1): in_ready becomes 1 after edge m. The minimum accept-to-accept period is NIB+2 cycles.
- All outputs are registered except in_ready, which decodes state and rst. The CLA slice path is combinational within one cycle.
- out_ready held low: out_valid, sum, cout and ovf stay constant indefinitely.

## Structure
- Shared package nibble_adder_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the NIBBLE_W=4 constant;
  - a function to derive NIB and the idx width, $clog2(NIB) with a minimum of 1.
- One sub-module: the existing CarryLookAhead_Adder, instantiated once unchanged (Sum, Cout, A, B, Cin), with A/B driven by the idx-selected nibbles and Cin by carry_reg.
- The top level holds the FSM, idx counter, operand latches, carry register and result register.

## Test plan
- 0xFFFF + 0x0001, cin=0 → sum 0x0000, cout 1, ovf 0, out_valid exactly 5 cycles after accept.
- 0x7FFF + 0x0001, cin=0 → sum 0x8000, cout 0, ovf 1. Also 0x8000 + 0x8000 → sum 0x0000, cout 1, ovf 1.
- WIDTH=4: 0xA + 0xF, cin=0 → sum 0x9, cout 1, latency 2. Then 0xA + 0xF, cin=1 → sum 0xA, cout 1.
- Backpressure: 0x1234 + 0x4321, cin=1, with out_ready low for 6 cycles:
  - sum 0x5556 is held stable and in_ready stays 0 throughout;
  - in_valid pulses with other operands during this window are ignored;
  - after the out_ready handshake, in_ready goes to 1 on the next cycle.
- Reset mid-RUN: assert rst for 1 cycle at the second RUN cycle of 0x00FF + 0x0001:
  - all outputs read 0 and no out_valid appears;
  - the next operation, 0x0003 + 0x0004, returns 0x0007 with correct latency.
- Random back-to-back: 500 operand pairs with random in_valid/out_ready; each result matches a+b+cin, with ovf and cout checked against the reference model, with no dropped or duplicated transactions.
